// File: rtl/instr_tagged_encoder.sv
// Packs Add/JmpU/JmpC fields into the 16-bit tagged-union Instr image
// and queues them in a small FIFO with saturating per-kind counters.
module instr_tagged_encoder #(
   parameter int FIFO_DEPTH = 2,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [4:0]       in_ra,
   input  logic [4:0]       in_rb,
   input  logic [4:0]       in_rd,
   input  logic [1:0]       in_cc,
   input  logic [9:0]       in_addr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_instr,
   output logic             err_op,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] cnt_add,
   output logic [CNT_W-1:0] cnt_jmp
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_JMPU = 2'b01;
   localparam logic [1:0] OP_JMPC = 2'b10;

   logic [15:0]      mem_q [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    occ_q, occ_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] add_q, add_d;
   logic [CNT_W-1:0] jmp_q, jmp_d;
   logic [15:0]      word;
   logic             accept, push, pop, is_rsv;

   // in_ready depends only on registered occupancy, never on out_ready
   assign in_ready  = rst_n && (occ_q < DEPTH_C);
   assign out_valid = (occ_q != '0);
   assign out_instr = out_valid ? mem_q[rd_ptr_q] : 16'h0000;
   assign err_op    = err_q;
   assign cnt_add   = add_q;
   assign cnt_jmp   = jmp_q;

   assign is_rsv = (in_op == 2'b11);
   assign accept = in_valid && in_ready;
   assign push   = accept && !is_rsv;
   assign pop    = out_valid && out_ready;

   always_comb begin
      word = 16'h0000;
      case (in_op)
         OP_ADD:  word = {1'b0, in_ra, in_rb, in_rd};
         OP_JMPU: word = {4'b1000, 2'b00, in_addr};
         OP_JMPC: word = {4'b1001, in_cc, in_addr};
         default: word = 16'h0000;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   occ_d = occ_q + CW'(1);
         2'b01:   occ_d = occ_q - CW'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_comb begin
      err_d = accept && is_rsv;
      add_d = add_q;
      jmp_d = jmp_q;
      if (clr_cnt) begin
         add_d = '0;
         jmp_d = '0;
      end else if (push) begin
         if (in_op == OP_ADD) begin
            if (add_q != '1) add_d = add_q + CNT_W'(1);
         end else begin
            if (jmp_q != '1) jmp_d = jmp_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         err_q    <= 1'b0;
         add_q    <= '0;
         jmp_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         err_q    <= err_d;
         add_q    <= add_d;
         jmp_q    <= jmp_d;
      end
   end

   // storage needs no reset: out_instr is masked while empty
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= word;
   end

endmodule

// File: tb/tb_instr_tagged_encoder.sv
// Scoreboard bench for instr_tagged_encoder (CNT_W=2 to reach saturation).
module tb_instr_tagged_encoder;

   localparam int DEPTH = 2;
   localparam int CW    = 2;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    in_op = '0;
   logic [4:0]    in_ra = '0, in_rb = '0, in_rd = '0;
   logic [1:0]    in_cc = '0;
   logic [9:0]    in_addr = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [15:0]   out_instr;
   logic          err_op;
   logic          clr_cnt = 1'b0;
   logic [CW-1:0] cnt_add, cnt_jmp;

   logic [15:0] cur_exp = '0;
   logic [15:0] sb[$];
   int          n_chk = 0;
   int          n_err = 0;
   int          m_add = 0, m_jmp = 0;
   logic        exp_err = 1'b0;
   logic        armed = 1'b0;
   logic        rand_on = 1'b0;

   instr_tagged_encoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd),
      .in_cc(in_cc), .in_addr(in_addr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .err_op(err_op),
      .clr_cnt(clr_cnt), .cnt_add(cnt_add), .cnt_jmp(cnt_jmp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] enc(input logic [1:0] op,
      input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
      input logic [1:0] cc, input logic [9:0] addr);
      case (op)
         2'd0:    return {1'b0, ra, rb, rd};
         2'd1:    return {6'b100000, addr};
         2'd2:    return {4'b1001, cc, addr};
         default: return 16'h0000;
      endcase
   endfunction

   // model state reflects the DUT after the most recent rising edge
   always @(negedge clk) begin
      logic fire, pop;
      if (armed) begin
         chk("in_ready", in_ready, rst_n && (sb.size() < DEPTH));
         chk("out_valid", out_valid, sb.size() != 0);
         chk("out_instr", out_instr, sb.size() != 0 ? sb[0] : 16'h0);
         chk("err_op", err_op, exp_err);
         chk("cnt_add", cnt_add, m_add);
         chk("cnt_jmp", cnt_jmp, m_jmp);
      end
      if (!rst_n) begin
         sb.delete();
         m_add = 0;
         m_jmp = 0;
         exp_err = 1'b0;
         armed = 1'b1;
      end else begin
         fire = in_valid && in_ready;
         pop  = out_valid && out_ready;
         exp_err = fire && (in_op == 2'd3);
         if (pop && sb.size() != 0) void'(sb.pop_front());
         if (fire && in_op != 2'd3) sb.push_back(cur_exp);
         if (clr_cnt) begin
            m_add = 0;
            m_jmp = 0;
         end else if (fire && in_op == 2'd0) begin
            if (m_add < CMAX) m_add++;
         end else if (fire && in_op != 2'd3) begin
            if (m_jmp < CMAX) m_jmp++;
         end
      end
   end

   always @(posedge clk) begin
      if (rand_on) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send(input logic [1:0] op, input logic [4:0] ra,
      input logic [4:0] rb, input logic [4:0] rd, input logic [1:0] cc,
      input logic [9:0] addr, input logic [15:0] exp);
      int n;
      in_op = op; in_ra = ra; in_rb = rb; in_rd = rd;
      in_cc = cc; in_addr = addr; cur_exp = exp;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) chk("accept_timeout", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      send(2'd0, 5'd1, 5'd2, 5'd3, 2'd0, 10'h0, 16'h0443);
      @(negedge clk);
      chk("t1_valid", out_valid, 1);
      chk("t1_instr", out_instr, 16'h0443);
      chk("t1_cnt_add", cnt_add, 1);
      @(posedge clk); #1;

      send(2'd1, 5'd9, 5'd9, 5'd9, 2'd3, 10'h155, 16'h8155);
      send(2'd2, 5'd0, 5'd0, 5'd0, 2'd2, 10'h3FF, 16'h9BFF);
      @(negedge clk);
      chk("t2_instr", out_instr, 16'h9BFF);
      chk("t2_cnt_jmp", cnt_jmp, 2);
      @(posedge clk); #1;

      out_ready = 1'b0;
      send(2'd0, 5'd4, 5'd5, 5'd6, 2'd0, 10'h0, 16'h10A6);
      send(2'd1, 5'd0, 5'd0, 5'd0, 2'd0, 10'h001, 16'h8001);
      fork
         send(2'd2, 5'd0, 5'd0, 5'd0, 2'd1, 10'h020, 16'h9420);
         begin
            repeat (3) @(negedge clk);
            chk("t3_full_block", in_ready, 0);
            chk("t3_head", out_instr, 16'h10A6);
            @(posedge clk); #2;
            out_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk); #1;

      send(2'd3, 5'd1, 5'd1, 5'd1, 2'd1, 10'h3FF, 16'h0000);
      @(negedge clk);
      chk("t4_err", err_op, 1);
      chk("t4_valid", out_valid, 0);
      @(negedge clk);
      chk("t4_err_once", err_op, 0);
      @(posedge clk); #1;

      out_ready = 1'b0;
      send(2'd0, 5'd7, 5'd8, 5'd9, 2'd0, 10'h0, 16'h1D09);
      send(2'd0, 5'd31, 5'd31, 5'd31, 2'd0, 10'h0, 16'h7FFF);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("t5_valid", out_valid, 0);
      chk("t5_instr", out_instr, 0);
      chk("t5_cnt_add", cnt_add, 0);
      chk("t5_ready", in_ready, 1);
      @(posedge clk); #1;

      repeat (5) send(2'd0, 5'd1, 5'd1, 5'd1, 2'd0, 10'h0, 16'h0421);
      @(negedge clk);
      chk("t6_sat", cnt_add, 3);
      @(posedge clk); #1;
      clr_cnt = 1'b1;
      send(2'd0, 5'd2, 5'd2, 5'd2, 2'd0, 10'h0, 16'h0842);
      clr_cnt = 1'b0;
      @(negedge clk);
      chk("t6_clr", cnt_add, 0);
      @(posedge clk); #1;

      rand_on = 1'b1;
      for (int i = 0; i < 60; i++) begin
         logic [1:0] op;
         logic [4:0] ra, rb, rd;
         logic [1:0] cc;
         logic [9:0] ad;
         op = 2'($urandom_range(0, 3));
         ra = 5'($urandom); rb = 5'($urandom); rd = 5'($urandom);
         cc = 2'($urandom); ad = 10'($urandom);
         send(op, ra, rb, rd, cc, ad, enc(op, ra, rb, rd, cc, ad));
      end
      rand_on = 1'b0;
      @(posedge clk); #2;
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("drain", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
